// File: rtl/maestro_hci_mode_ctrl_pkg.sv
// Shared types for the maestro HCI wide/narrow mode sequencer.
// Holds the FSM state encoding and the sel_o polarity constants.
package maestro_hci_mode_ctrl_pkg;

    typedef enum logic [1:0] {
        MC_RUN,
        MC_DRAIN,
        MC_SWITCH,
        MC_SETTLE
    } mode_ctrl_state_e;

    localparam logic MODE_NARROW = 1'b0;
    localparam logic MODE_WIDE   = 1'b1;

endpackage

// File: rtl/maestro_hci_mode_ctrl_if.sv
// Mode-change request handshake: the requester holds valid/sel until ready pulses.
// Ready is a single-cycle acknowledge and may arrive in the same cycle as valid.
interface maestro_hci_mode_ctrl_if;

    logic mode_valid;
    logic mode_sel;
    logic mode_ready;

    modport master (
        output mode_valid,
        output mode_sel,
        input  mode_ready
    );

    modport slave (
        input  mode_valid,
        input  mode_sel,
        output mode_ready
    );

endinterface

// File: rtl/maestro_hci_outstanding_cnt.sv
// Granted-but-not-returned transaction counter; saturates at MAX_OUTSTANDING and at 0.
// Any overflow or underflow raises a sticky error, cleared only by reset or clear_i.
module maestro_hci_outstanding_cnt #(
    parameter int unsigned MAX_OUTSTANDING = 4,
    parameter int unsigned CW              = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          clear_i,
    input  logic          inc_i,
    input  logic          dec_i,
    output logic [CW-1:0] cnt_o,
    output logic          err_o
);

    logic [CW-1:0] cnt_q;
    logic          err_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else if (clear_i) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else if (inc_i && !dec_i) begin
            if (cnt_q == CW'(MAX_OUTSTANDING)) begin
                err_q <= 1'b1;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end else if (dec_i && !inc_i) begin
            // an r_valid with nothing in flight means the tracking is out of sync
            if (cnt_q == '0) begin
                err_q <= 1'b1;
            end else begin
                cnt_q <= cnt_q - 1'b1;
            end
        end
    end

    assign cnt_o = cnt_q;
    assign err_o = err_q;

endmodule

// File: rtl/maestro_hci_mode_ctrl.sv
// Sequences the interconnect wide/narrow sel: gate new requests, drain in-flight, flip, settle, reopen.
// No-op change acks in 0 cycles; a real change takes drain time + 1 + SETTLE_CYCLES.
module maestro_hci_mode_ctrl
    import maestro_hci_mode_ctrl_pkg::*;
#(
    parameter int unsigned MAX_OUTSTANDING = 4,
    parameter int unsigned SETTLE_CYCLES   = 1,
    parameter logic        RESET_SEL       = MODE_WIDE,
    parameter int unsigned CW              = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          clear_i,
    maestro_hci_mode_ctrl_if.slave        mode,
    output logic                          sel_o,
    input  logic                          in_req_i,
    output logic                          in_gnt_o,
    output logic                          out_req_o,
    input  logic                          out_gnt_i,
    input  logic                          out_rvalid_i,
    output logic                          busy_o,
    output logic [CW-1:0]                 outstanding_o,
    output logic                          err_o
);

    localparam int unsigned SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    mode_ctrl_state_e state_q;
    logic             sel_q;
    logic [SW-1:0]    settle_q;
    logic             pend;
    logic             open;
    logic             settle_done;

    assign pend        = mode.mode_valid & (mode.mode_sel != sel_q);
    assign open        = (state_q == MC_RUN) & ~pend;
    assign settle_done = (state_q == MC_SETTLE) & (settle_q == '0);

    assign out_req_o = in_req_i & open;
    assign in_gnt_o  = out_gnt_i & out_req_o;
    assign busy_o    = (state_q != MC_RUN) | pend;
    assign sel_o     = sel_q;

    // a soft clear aborts the settle, so the exit acknowledge is suppressed with it
    assign mode.mode_ready = ((state_q == MC_RUN) & mode.mode_valid & ~pend)
                           | (settle_done & ~clear_i);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q  <= MC_RUN;
            sel_q    <= RESET_SEL;
            settle_q <= '0;
        end else if (clear_i) begin
            state_q  <= MC_RUN;
            settle_q <= '0;
        end else begin
            case (state_q)
                MC_RUN: begin
                    if (pend) begin
                        state_q <= MC_DRAIN;
                    end
                end
                MC_DRAIN: begin
                    if ((outstanding_o == '0) && !out_rvalid_i) begin
                        state_q <= MC_SWITCH;
                    end
                end
                MC_SWITCH: begin
                    sel_q    <= mode.mode_sel;
                    settle_q <= SW'(SETTLE_CYCLES - 1);
                    state_q  <= MC_SETTLE;
                end
                MC_SETTLE: begin
                    if (settle_q == '0) begin
                        state_q <= MC_RUN;
                    end else begin
                        settle_q <= settle_q - 1'b1;
                    end
                end
                default: begin
                    state_q <= MC_RUN;
                end
            endcase
        end
    end

    maestro_hci_outstanding_cnt #(
        .MAX_OUTSTANDING (MAX_OUTSTANDING),
        .CW              (CW)
    ) u_outstanding_cnt (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clear_i (clear_i),
        .inc_i   (in_gnt_o),
        .dec_i   (out_rvalid_i),
        .cnt_o   (outstanding_o),
        .err_o   (err_o)
    );

endmodule

// File: tb/tb_maestro_hci_mode_ctrl.sv
// Directed bench for maestro_hci_mode_ctrl; mode_ready pulses are matched against a scoreboard
// of expected {cycle, sel} entries pushed when each request is driven.
module tb_maestro_hci_mode_ctrl;

    localparam int unsigned MAX_OUT = 4;
    localparam int unsigned SETTLE  = 1;
    localparam int unsigned CW      = $clog2(MAX_OUT + 1);

    // Expected per-cycle values for the 3-in-flight switch, bit k = cycle k after the pend cycle
    localparam logic [7:0] SW_REQ  = 8'b1000_0000;
    localparam logic [7:0] SW_SEL  = 8'b0011_1111;
    localparam logic [7:0] SW_BUSY = 8'b0111_1111;
    localparam logic [7:0] SW_RV   = 8'b0000_1110;
    localparam logic [2:0] SW_CNT [8] = '{3'd3, 3'd3, 3'd2, 3'd1, 3'd0, 3'd0, 3'd0, 3'd0};

    typedef struct {
        int   cyc;
        logic sel;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          clear;
    logic          sel;
    logic          in_req;
    logic          in_gnt;
    logic          out_req;
    logic          out_gnt;
    logic          out_rvalid;
    logic          busy;
    logic [CW-1:0] outstanding;
    logic          err;

    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    exp_t sb_q[$];

    maestro_hci_mode_ctrl_if mode_if ();

    maestro_hci_mode_ctrl #(
        .MAX_OUTSTANDING (MAX_OUT),
        .SETTLE_CYCLES   (SETTLE),
        .RESET_SEL       (1'b1)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .clear_i       (clear),
        .mode          (mode_if.slave),
        .sel_o         (sel),
        .in_req_i      (in_req),
        .in_gnt_o      (in_gnt),
        .out_req_o     (out_req),
        .out_gnt_i     (out_gnt),
        .out_rvalid_i  (out_rvalid),
        .busy_o        (busy),
        .outstanding_o (outstanding),
        .err_o         (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input int c, input logic s);
        exp_t e;
        e.cyc = c;
        e.sel = s;
        sb_q.push_back(e);
    endtask

    // Scoreboard consumer: every mode_ready pulse must match the oldest expected entry
    always @(negedge clk) begin
        if (mode_if.mode_ready === 1'b1) begin
            check_eq("sb_ready_expected", 32'(sb_q.size() != 0), 1);
            if (sb_q.size() != 0) begin
                exp_t e;
                e = sb_q.pop_front();
                check_eq("sb_ready_cycle", 32'(cyc), 32'(e.cyc));
                check_eq("sb_ready_sel", 32'(sel), 32'(e.sel));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int p;
        rst_n              = 1'b0;
        clear              = 1'b0;
        in_req             = 1'b1;
        out_gnt            = 1'b1;
        out_rvalid         = 1'b0;
        mode_if.mode_valid = 1'b0;
        mode_if.mode_sel   = 1'b1;

        // reset state
        next_cycle();
        @(negedge clk);
        check_eq("rst_sel", 32'(sel), 1);
        check_eq("rst_out_req", 32'(out_req), 1);
        check_eq("rst_in_gnt", 32'(in_gnt), 1);
        check_eq("rst_err", 32'(err), 0);
        check_eq("rst_outstanding", 32'(outstanding), 0);
        check_eq("rst_busy", 32'(busy), 0);
        next_cycle();
        rst_n  = 1'b1;
        in_req = 1'b0;
        @(negedge clk);

        // same-mode request: acknowledged in-cycle, traffic stays open
        next_cycle();
        mode_if.mode_valid = 1'b1;
        mode_if.mode_sel   = 1'b1;
        in_req             = 1'b1;
        push_exp(cyc, 1'b1);
        @(negedge clk);
        check_eq("noop_out_req", 32'(out_req), 1);
        check_eq("noop_in_gnt", 32'(in_gnt), 1);
        check_eq("noop_busy", 32'(busy), 0);
        next_cycle();
        mode_if.mode_valid = 1'b0;
        in_req             = 1'b0;
        @(negedge clk);
        check_eq("noop_outstanding", 32'(outstanding), 1);
        next_cycle();
        out_rvalid = 1'b1;
        next_cycle();
        out_rvalid = 1'b0;
        @(negedge clk);
        check_eq("noop_drained", 32'(outstanding), 0);

        // switch to narrow with 3 in flight
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            in_req = 1'b1;
        end
        next_cycle();
        mode_if.mode_valid = 1'b1;
        mode_if.mode_sel   = 1'b0;
        p = cyc;
        push_exp(p + 6, 1'b0);
        for (int k = 0; k < 8; k++) begin
            if (k > 0) next_cycle();
            out_rvalid         = SW_RV[k];
            mode_if.mode_valid = (k <= 6);
            @(negedge clk);
            check_eq($sformatf("sw_out_req_%0d", k), 32'(out_req), 32'(SW_REQ[k]));
            check_eq($sformatf("sw_in_gnt_%0d", k), 32'(in_gnt), 32'(SW_REQ[k]));
            check_eq($sformatf("sw_sel_%0d", k), 32'(sel), 32'(SW_SEL[k]));
            check_eq($sformatf("sw_busy_%0d", k), 32'(busy), 32'(SW_BUSY[k]));
            check_eq($sformatf("sw_cnt_%0d", k), 32'(outstanding), 32'(SW_CNT[k]));
        end
        next_cycle();
        in_req     = 1'b0;
        out_rvalid = 1'b1;
        @(negedge clk);
        check_eq("sw_resumed_cnt", 32'(outstanding), 1);
        next_cycle();
        out_rvalid = 1'b0;
        @(negedge clk);
        check_eq("sw_resumed_drained", 32'(outstanding), 0);

        // simultaneous grant and r_valid at count 2, then underflow
        next_cycle(); in_req = 1'b1;
        next_cycle(); in_req = 1'b1;
        next_cycle(); in_req = 1'b1; out_rvalid = 1'b1;
        @(negedge clk);
        check_eq("simul_pre_cnt", 32'(outstanding), 2);
        next_cycle(); in_req = 1'b0; out_rvalid = 1'b0;
        @(negedge clk);
        check_eq("simul_cnt", 32'(outstanding), 2);
        check_eq("simul_err", 32'(err), 0);
        next_cycle(); out_rvalid = 1'b1;
        next_cycle();
        next_cycle();
        @(negedge clk);
        check_eq("underflow_pre_err", 32'(err), 0);
        next_cycle(); out_rvalid = 1'b0;
        @(negedge clk);
        check_eq("underflow_err", 32'(err), 1);
        check_eq("underflow_cnt", 32'(outstanding), 0);
        next_cycle();
        @(negedge clk);
        check_eq("underflow_sticky", 32'(err), 1);
        next_cycle(); clear = 1'b1;
        next_cycle(); clear = 1'b0;
        @(negedge clk);
        check_eq("clear_err", 32'(err), 0);

        // saturation at MAX_OUTSTANDING
        for (int i = 0; i < 5; i++) begin
            next_cycle();
            in_req = 1'b1;
            @(negedge clk);
            if (i == 4) begin
                check_eq("sat_full_cnt", 32'(outstanding), MAX_OUT);
                check_eq("sat_full_err", 32'(err), 0);
            end
        end
        next_cycle(); in_req = 1'b0;
        @(negedge clk);
        check_eq("sat_cnt", 32'(outstanding), MAX_OUT);
        check_eq("sat_err", 32'(err), 1);
        next_cycle(); clear = 1'b1;
        next_cycle(); clear = 1'b0;
        @(negedge clk);
        check_eq("sat_clear_cnt", 32'(outstanding), 0);
        check_eq("sat_clear_err", 32'(err), 0);

        // empty-counter switch back to wide: ack 2+SETTLE cycles after the pend cycle
        next_cycle();
        mode_if.mode_valid = 1'b1;
        mode_if.mode_sel   = 1'b1;
        push_exp(cyc + 2 + SETTLE, 1'b1);
        repeat (2 + SETTLE) next_cycle();
        @(negedge clk);
        check_eq("empty_sw_sel", 32'(sel), 1);
        next_cycle();
        mode_if.mode_valid = 1'b0;
        @(negedge clk);
        check_eq("empty_sw_busy", 32'(busy), 0);

        // switch to narrow, then clear during SETTLE
        next_cycle();
        mode_if.mode_valid = 1'b1;
        mode_if.mode_sel   = 1'b0;
        repeat (2) next_cycle();
        next_cycle();
        clear = 1'b1;
        @(negedge clk);
        check_eq("clr_settle_sel", 32'(sel), 0);
        check_eq("clr_settle_ready", 32'(mode_if.mode_ready), 0);
        next_cycle();
        clear              = 1'b0;
        mode_if.mode_valid = 1'b0;
        in_req             = 1'b1;
        @(negedge clk);
        check_eq("clr_busy", 32'(busy), 0);
        check_eq("clr_sel", 32'(sel), 0);
        check_eq("clr_cnt", 32'(outstanding), 0);
        check_eq("clr_out_req", 32'(out_req), 1);
        next_cycle(); in_req = 1'b1;
        next_cycle(); in_req = 1'b0;

        // reset during DRAIN, request retried afterwards
        next_cycle();
        mode_if.mode_valid = 1'b1;
        mode_if.mode_sel   = 1'b1;
        @(negedge clk);
        check_eq("rdrain_busy", 32'(busy), 1);
        check_eq("rdrain_cnt", 32'(outstanding), 2);
        next_cycle();
        rst_n = 1'b0;
        @(negedge clk);
        check_eq("rdrain_gated", 32'(dut.state_q != dut.state_q.first()), 1);
        next_cycle();
        rst_n  = 1'b1;
        in_req = 1'b1;
        push_exp(cyc, 1'b1);
        @(negedge clk);
        check_eq("rdrain_sel", 32'(sel), 1);
        check_eq("rdrain_cnt_after", 32'(outstanding), 0);
        check_eq("rdrain_busy_after", 32'(busy), 0);
        check_eq("rdrain_out_req", 32'(out_req), 1);
        next_cycle();
        mode_if.mode_valid = 1'b0;
        in_req             = 1'b0;
        repeat (3) next_cycle();
        @(negedge clk);
        check_eq("sb_empty", 32'(sb_q.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
